// File: rtl/layer_sequencer_pkg.sv
// Shared definitions for the layer run sequencer: state encoding and default widths.
package layer_sequencer_pkg;

    localparam int unsigned WV_DEF = 5;
    localparam int unsigned WS_DEF = 16;
    localparam int unsigned WE_DEF = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        FWD   = 3'd2,
        BWD   = 3'd3,
        NEXT  = 3'd4,
        DONE  = 3'd5
    } seqState_t;

endpackage

// File: rtl/layer_sequencer_seq_counter.sv
// Sample index / epoch counter pair with terminal-count flags against the latched limits.
module seq_counter
    import layer_sequencer_pkg::*;
#(
    parameter int unsigned WS = WS_DEF,
    parameter int unsigned WE = WE_DEF
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          clear,
    input  logic          incr,
    input  logic [WS-1:0] numSample,
    input  logic [WE-1:0] numEpoch,
    output logic [WS-1:0] idx,
    output logic [WE-1:0] epoch,
    output logic          lastIdx_c,
    output logic          lastEpoch_c
);

    assign lastIdx_c   = (idx == numSample - WS'(1));
    assign lastEpoch_c = (epoch == numEpoch - WE'(1));

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            idx   <= '0;
            epoch <= '0;
        end else if (clear) begin
            idx   <= '0;
            epoch <= '0;
        end else if (incr) begin
            // index rolls over into the next epoch; the epoch itself never wraps within a run
            if (lastIdx_c) begin
                idx   <= '0;
                epoch <= epoch + WE'(1);
            end else begin
                idx <= idx + WS'(1);
            end
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Run-level controller: issues samples, waits for forward (and backward) completion per pass.
// Optional: LAYER_SEQUENCER_LR_DECAY_EN halves the learning rate at each non-final epoch boundary.
module layer_sequencer #(
    parameter int unsigned WV = layer_sequencer_pkg::WV_DEF,
    parameter int unsigned WS = layer_sequencer_pkg::WS_DEF,
    parameter int unsigned WE = layer_sequencer_pkg::WE_DEF
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iStart,
    input  logic          iAbort,
    input  logic          iTrain,
    input  logic [WS-1:0] iNumSample,
    input  logic [WE-1:0] iNumEpoch,
    input  logic [WV-1:0] iLR,
    output logic          oMode,
    output logic [WV-1:0] oLR,
    output logic          oValid_Sample,
    input  logic          iReady_Sample,
    output logic [WS-1:0] oSampleIdx,
    input  logic          iFwdDone,
    input  logic          iBwdDone,
    output logic          oBusy,
    output logic          oDone,
    output logic [WE-1:0] oEpoch
);

    import layer_sequencer_pkg::*;

    seqState_t     state;
    logic          trainQ;
    logic [WS-1:0] numSampleQ;
    logic [WE-1:0] numEpochQ;

    logic          cntClear;
    logic          cntIncr;
    logic [WS-1:0] cntIdx;
    logic          cntLastIdx;
    logic          cntLastEpoch;

`ifdef LAYER_SEQUENCER_LR_DECAY_EN
    logic          lrNonZero;
    logic [WV-1:0] lrHalf;
    assign lrHalf = oLR >> 1;
`endif

    assign cntClear = (state == IDLE) && iStart && !iAbort;
    assign cntIncr  = (state == NEXT) && !iAbort;

    seq_counter #(
        .WS(WS),
        .WE(WE)
    ) uCounter (
        .clk        (iCLK),
        .rstN       (iRST),
        .clear      (cntClear),
        .incr       (cntIncr),
        .numSample  (numSampleQ),
        .numEpoch   (numEpochQ),
        .idx        (cntIdx),
        .epoch      (oEpoch),
        .lastIdx_c  (cntLastIdx),
        .lastEpoch_c(cntLastEpoch)
    );

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state         <= IDLE;
            trainQ        <= 1'b0;
            numSampleQ    <= '0;
            numEpochQ     <= '0;
            oMode         <= 1'b0;
            oLR           <= '0;
            oValid_Sample <= 1'b0;
            oSampleIdx    <= '0;
            oBusy         <= 1'b0;
            oDone         <= 1'b0;
`ifdef LAYER_SEQUENCER_LR_DECAY_EN
            lrNonZero     <= 1'b0;
`endif
        end else if (iAbort) begin
            // mode and learning rate stay as they were
            state         <= IDLE;
            oValid_Sample <= 1'b0;
            oBusy         <= 1'b0;
            oDone         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    oDone <= 1'b0;
                    if (iStart) begin
                        trainQ     <= iTrain;
                        numSampleQ <= iNumSample;
                        numEpochQ  <= iNumEpoch;
                        oMode      <= iTrain;
                        oLR        <= iLR;
                        oSampleIdx <= '0;
                        oBusy      <= 1'b1;
`ifdef LAYER_SEQUENCER_LR_DECAY_EN
                        lrNonZero  <= (iLR != '0);
`endif
                        if ((iNumSample == '0) || (iTrain && (iNumEpoch == '0))) begin
                            state <= DONE;
                            oDone <= 1'b1;
                        end else begin
                            state         <= ISSUE;
                            oValid_Sample <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (iReady_Sample) begin
                        oValid_Sample <= 1'b0;
                        state         <= FWD;
                    end
                end
                FWD: begin
                    if (iFwdDone) begin
                        state <= trainQ ? BWD : NEXT;
                    end
                end
                BWD: begin
                    if (iBwdDone) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (cntLastIdx && (!trainQ || cntLastEpoch)) begin
                        state <= DONE;
                        oDone <= 1'b1;
                    end else begin
                        state         <= ISSUE;
                        oValid_Sample <= 1'b1;
                        oSampleIdx    <= cntLastIdx ? '0 : cntIdx + WS'(1);
`ifdef LAYER_SEQUENCER_LR_DECAY_EN
                        if (cntLastIdx) begin
                            oLR <= ((lrHalf == '0) && lrNonZero) ? WV'(1) : lrHalf;
                        end
`endif
                    end
                end
                DONE: begin
                    oDone <= 1'b0;
                    oBusy <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state         <= IDLE;
                    oValid_Sample <= 1'b0;
                    oBusy         <= 1'b0;
                    oDone         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: expected issues/completions are queued at stimulus time.
module tb_layer_sequencer;

    localparam int unsigned WV = 5;
    localparam int unsigned WS = 16;
    localparam int unsigned WE = 8;

    logic          iCLK;
    logic          iRST;
    logic          iStart;
    logic          iAbort;
    logic          iTrain;
    logic [WS-1:0] iNumSample;
    logic [WE-1:0] iNumEpoch;
    logic [WV-1:0] iLR;
    logic          oMode;
    logic [WV-1:0] oLR;
    logic          oValid_Sample;
    logic          iReady_Sample;
    logic [WS-1:0] oSampleIdx;
    logic          iFwdDone;
    logic          iBwdDone;
    logic          oBusy;
    logic          oDone;
    logic [WE-1:0] oEpoch;

    layer_sequencer #(.WV(WV), .WS(WS), .WE(WE)) dut (
        .iCLK         (iCLK),
        .iRST         (iRST),
        .iStart       (iStart),
        .iAbort       (iAbort),
        .iTrain       (iTrain),
        .iNumSample   (iNumSample),
        .iNumEpoch    (iNumEpoch),
        .iLR          (iLR),
        .oMode        (oMode),
        .oLR          (oLR),
        .oValid_Sample(oValid_Sample),
        .iReady_Sample(iReady_Sample),
        .oSampleIdx   (oSampleIdx),
        .iFwdDone     (iFwdDone),
        .iBwdDone     (iBwdDone),
        .oBusy        (oBusy),
        .oDone        (oDone),
        .oEpoch       (oEpoch)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    typedef struct {
        int idx;
        int epoch;
        int mode;
        int lr;
    } issue_t;

    // field: 0 busy, 1 valid, 2 done, 3 epoch, 4 mode, 5 lr, 6 idx, 7 issue queue size, 8 done queue size, other = forced failure
    typedef struct {
        string name;
        int    field;
        int    exp;
    } chk_t;

    issue_t expQ[$];
    int     doneQ[$];
    chk_t   chkQ[$];

    int compared   = 0;
    int mismatched = 0;

    task automatic pushChk(input string n, input int f, input int e);
        chk_t c;
        c.name  = n;
        c.field = f;
        c.exp   = e;
        chkQ.push_back(c);
    endtask

    // ---------------- monitor ----------------
    logic          holdPrev = 1'b0;
    logic [WS-1:0] prevIdx  = '0;
    chk_t          mc;
    issue_t        me;
    int            mgot;
    int            md;

    task automatic cmp(input string n, input int got, input int exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", n, got, exp, $time);
        end
    endtask

    always @(negedge iCLK) begin
        while (chkQ.size() != 0) begin
            mc = chkQ.pop_front();
            case (mc.field)
                0:       mgot = int'(oBusy);
                1:       mgot = int'(oValid_Sample);
                2:       mgot = int'(oDone);
                3:       mgot = int'(oEpoch);
                4:       mgot = int'(oMode);
                5:       mgot = int'(oLR);
                6:       mgot = int'(oSampleIdx);
                7:       mgot = expQ.size();
                8:       mgot = doneQ.size();
                default: mgot = 1;
            endcase
            cmp(mc.name, mgot, mc.exp);
        end
        if (iRST) begin
            if (holdPrev) begin
                cmp("valid held under backpressure", int'(oValid_Sample), 1);
                cmp("index held under backpressure", int'(oSampleIdx), int'(prevIdx));
            end
            if (oValid_Sample && iReady_Sample) begin
                if (expQ.size() == 0) begin
                    cmp("unexpected handshake", 1, 0);
                end else begin
                    me = expQ.pop_front();
                    cmp("issue idx", int'(oSampleIdx), me.idx);
                    cmp("issue epoch", int'(oEpoch), me.epoch);
                    cmp("issue mode", int'(oMode), me.mode);
                    cmp("issue lr", int'(oLR), me.lr);
                end
            end
            if (oDone) begin
                if (doneQ.size() == 0) begin
                    cmp("unexpected done", 1, 0);
                end else begin
                    md = doneQ.pop_front();
                    cmp("final epoch", int'(oEpoch), md);
                    cmp("busy during done", int'(oBusy), 1);
                end
            end
            holdPrev = oValid_Sample && !iReady_Sample && !iAbort;
            prevIdx  = oSampleIdx;
        end else begin
            holdPrev = 1'b0;
        end
    end

    // ---------------- stimulus + reference model ----------------
    task automatic pushResetChecks(input string tag);
        pushChk({tag, " busy"}, 0, 0);
        pushChk({tag, " valid"}, 1, 0);
        pushChk({tag, " done"}, 2, 0);
        pushChk({tag, " epoch"}, 3, 0);
        pushChk({tag, " mode"}, 4, 0);
        pushChk({tag, " lr"}, 5, 0);
        pushChk({tag, " idx"}, 6, 0);
    endtask

    // readyMode: 0 tied high, 1 random, 2 low for the first 5 valid cycles
    // stopKind: 0 none, 1 abort in BWD of sample stopAt, 2 async reset in FWD of sample stopAt
    task automatic doRun(input int train, input int ns, input int ne, input int lr,
                         input int readyMode, input int fwdDelay, input int stopAt,
                         input int stopKind, input int stray);
        int  nEp, cur, pushed, lim, abortLr;
        bit  empty, finished, abortSent, strayRestore;
        int  cyc, hsCount, curSample, fwdCnt, bwdCnt, lowLeft;
        logic hsNow;

        nEp     = (train != 0) ? ne : 1;
        empty   = (ns == 0) || ((train != 0) && (ne == 0));
        cur     = lr;
        pushed  = 0;
        abortLr = lr;
        lim     = (stopKind == 0) ? 32'h7fffffff : stopAt + 1;
        if (!empty) begin
            for (int e = 0; e < nEp; e++) begin
                for (int i = 0; i < ns; i++) begin
                    if (pushed < lim) begin
                        issue_t it;
                        it.idx   = i;
                        it.epoch = e;
                        it.mode  = train;
                        it.lr    = cur;
                        expQ.push_back(it);
                        if (pushed == stopAt) abortLr = cur;
                    end
                    pushed++;
                end
`ifdef LAYER_SEQUENCER_LR_DECAY_EN
                if (e < nEp - 1) begin
                    cur = cur >> 1;
                    if (cur == 0 && lr != 0) cur = 1;
                end
`endif
            end
        end
        if (stopKind == 0) doneQ.push_back(empty ? 0 : nEp);

        iTrain        = (train != 0);
        iNumSample    = WS'(ns);
        iNumEpoch     = WE'(ne);
        iLR           = WV'(lr);
        iStart        = 1'b1;
        iReady_Sample = (readyMode == 2) ? 1'b0 : 1'b1;
        finished = 0; abortSent = 0; strayRestore = 0;
        cyc = 0; hsCount = 0; curSample = -1; fwdCnt = -1; bwdCnt = -1;
        lowLeft = (readyMode == 2) ? 5 : 0;

        while (!finished && cyc < 3000) begin
            hsNow = oValid_Sample && iReady_Sample;
            @(posedge iCLK); #1;
            cyc++;
            iStart   = 1'b0;
            iFwdDone = 1'b0;
            iBwdDone = 1'b0;
            if (abortSent) begin
                iAbort = 1'b0;
                pushChk("abort busy", 0, 0);
                pushChk("abort valid", 1, 0);
                pushChk("abort done", 2, 0);
                pushChk("abort mode held", 4, train);
                pushChk("abort lr held", 5, abortLr);
                return;
            end
            if (cyc == 1) begin
                pushChk("busy after start", 0, 1);
                if (empty) pushChk("no valid on empty run", 1, 0);
            end
            if (oDone) finished = 1;
            if (strayRestore) begin
                strayRestore = 0;
                iTrain     = (train != 0);
                iNumSample = WS'(ns);
                iLR        = WV'(lr);
            end
            if (bwdCnt == 0) begin
                bwdCnt = -1;
                if (stopKind == 1 && curSample == stopAt) begin
                    iAbort    = 1'b1;
                    abortSent = 1;
                end else begin
                    iBwdDone = 1'b1;
                end
            end else if (bwdCnt > 0) begin
                bwdCnt--;
            end
            if (hsNow) begin
                curSample = hsCount;
                hsCount++;
                fwdCnt = (fwdDelay < 0) ? int'($urandom_range(0, 3)) : fwdDelay;
                if (stopKind == 2 && curSample == stopAt) begin
                    #2;
                    iRST = 1'b0;
                    pushResetChecks("async reset");
                    @(posedge iCLK); #1;
                    iRST     = 1'b1;
                    iFwdDone = 1'b1;
                    @(posedge iCLK); #1;
                    iFwdDone = 1'b0;
                    pushChk("stray fwd busy", 0, 0);
                    pushChk("stray fwd valid", 1, 0);
                    return;
                end
            end
            if (fwdCnt == 0) begin
                fwdCnt   = -1;
                iFwdDone = 1'b1;
                if (train != 0) bwdCnt = int'($urandom_range(0, 3));
                if (stray != 0 && hsCount == 1) begin
                    iStart       = 1'b1;
                    iTrain       = (train == 0);
                    iNumSample   = WS'(ns + 5);
                    iLR          = ~WV'(lr);
                    strayRestore = 1;
                end
            end else if (fwdCnt > 0) begin
                fwdCnt--;
            end
            case (readyMode)
                0: iReady_Sample = 1'b1;
                1: iReady_Sample = ($urandom_range(0, 1) != 0);
                default: begin
                    if (lowLeft > 0 && oValid_Sample) begin
                        iReady_Sample = 1'b0;
                        lowLeft--;
                    end else begin
                        iReady_Sample = (lowLeft == 0);
                    end
                end
            endcase
        end
        if (!finished) begin
            pushChk("run timeout", 99, 0);
        end else begin
            @(posedge iCLK); #1;
            pushChk("busy cleared after done", 0, 0);
            pushChk("done one cycle", 2, 0);
        end
    endtask

    initial begin
        iRST          = 1'b0;
        iStart        = 1'b0;
        iAbort        = 1'b0;
        iTrain        = 1'b0;
        iNumSample    = '0;
        iNumEpoch     = '0;
        iLR           = '0;
        iReady_Sample = 1'b0;
        iFwdDone      = 1'b0;
        iBwdDone      = 1'b0;
        repeat (3) @(posedge iCLK);
        #1;
        pushResetChecks("reset");
        @(posedge iCLK); #1;
        iRST = 1'b1;
        @(posedge iCLK); #1;

        doRun(0, 3, 5, 13, 0, 2, -1, 0, 0);
        doRun(1, 2, 3, 8, 0, -1, -1, 0, 0);
        doRun(0, 2, 1, 3, 2, 1, -1, 0, 0);
        doRun(1, 0, 2, 5, 0, 0, -1, 0, 0);
        doRun(1, 3, 2, 6, 0, -1, 1, 1, 0);
        doRun(1, 2, 2, 6, 1, -1, -1, 0, 0);
        doRun(1, 3, 2, 9, 0, -1, 1, 2, 0);
        doRun(1, 2, 2, 4, 1, -1, -1, 0, 1);
        doRun(1, 1, 4, 1, 0, 0, -1, 0, 0);
        doRun(1, 2, 3, 0, 0, 0, -1, 0, 0);
        for (int r = 0; r < 12; r++) begin
            doRun(int'($urandom_range(0, 1)), int'($urandom_range(1, 4)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
                  1, -1, -1, 0, 0);
        end

        pushChk("issue scoreboard drained", 7, 0);
        pushChk("done scoreboard drained", 8, 0);
        @(negedge iCLK); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
Run-level controller for one HiddenLayer/OutputLayer network instance. Given a sample count, an epoch count and a learning rate, it issues one sample per pass to the state source and waits for the forward-pass completion. In training mode it also waits for the backward/weight-update completion before issuing the next sample. It drives the layers' iMode and iLR inputs and holds both stable for the whole run.

Parameters:
WV, 5, value word width (matches layer WV; width of learning rate)
WS, 16, sample index/count width
WE, 8, epoch index/count width

Ports:
iCLK  in  1  clock
iRST  in  1  asynchronous active-low reset
iStart  in  1  start pulse; sampled only in IDLE
iAbort  in  1  synchronous abort; returns to IDLE
iTrain  in  1  1 = training run, 0 = inference run; latched at start
iNumSample  in  WS  samples per epoch; latched at start
iNumEpoch  in  WE  epochs; latched at start; ignored for inference
iLR  in  WV  initial learning rate; latched at start
oMode  out  1  to layer iMode
oLR  out  WV  to layer iLR
oValid_Sample  out  1  request next sample from source
iReady_Sample  in  1  source accepts request
oSampleIdx  out  WS  index of the requested sample
iFwdDone  in  1  one-cycle pulse: final-layer State0 handshake completed
iBwdDone  in  1  one-cycle pulse: first-layer weight update completed
oBusy  out  1  high outside IDLE
oDone  out  1  one-cycle pulse on normal completion
oEpoch  out  WE  current epoch index

Behaviour:
- Reset values: oMode=0, oLR=0, oValid_Sample=0, oSampleIdx=0, oBusy=0, oDone=0, oEpoch=0; state=IDLE.
- States: IDLE, ISSUE, FWD, BWD, NEXT, DONE.
- IDLE:
  - On iStart, latch iTrain, iNumSample, iNumEpoch and iLR.
  - Set oMode=iTrain and oLR=iLR.
  - If iNumSample==0, or (iTrain && iNumEpoch==0), go to DONE. Otherwise go to ISSUE.
- ISSUE:
  - oValid_Sample=1; hold it and oSampleIdx until iReady_Sample.
  - On handshake, go to FWD. oValid_Sample drops the following cycle.
- FWD: wait for iFwdDone. Then go to BWD if training, else NEXT.
- BWD: wait for iBwdDone, then go to NEXT.
- NEXT (one cycle):
  - If idx==NumSample-1: set idx=0 and epoch+1.
    - Finish (go to DONE) if inference, or if epoch==NumEpoch-1. Otherwise go to ISSUE.
  - Else: idx+1, go to ISSUE.
- DONE: oDone=1 for exactly one cycle, then IDLE. oEpoch keeps its final value until the next start.
- oBusy=1 in every state except IDLE; it is registered.
- oMode and oLR change only on the IDLE→run transition (oLR also per LR_DECAY_EN). They are never changed mid-pass.
- iStart outside IDLE is ignored. iFwdDone/iBwdDone outside their wait states are ignored, not queued.
- iAbort has priority over every other event. Next cycle: IDLE, oValid_Sample=0, no oDone. oMode and oLR are held.
- Async reset mid-run: immediate return to reset values.
- Minimum per-sample latency is handshake + 1 (FWD) + 1 (NEXT), excluding wait time.
- Counters compare against the latched value minus one using WS/WE-bit arithmetic. There is no wrap beyond the count.

Optional Feature:
- Macro LAYER_SEQUENCER_LR_DECAY_EN.
- Defined: in NEXT, on each epoch boundary that does not finish the run, oLR <= oLR>>1, floored at 1 when the latched iLR was nonzero.
- Undefined: oLR is constant for the run; no decay logic is synthesized.

Decomposition:
- Shared package: the state enumeration constants (IDLE..DONE, 3-bit encoding) and the WS/WE default widths used by the top-level network wrapper.
- One natural sub-module, seq_counter: an index/epoch pair with terminal-count flags. It takes the latched limits, an increment strobe and a clear, and outputs idx, epoch, last_idx and last_epoch.

Test Plan:
- Inference, NumSample=3, iReady_Sample tied 1, iFwdDone 2 cycles after each issue:
  - oSampleIdx 0,1,2; oMode=0 throughout.
  - No wait in BWD; oDone pulses once; oEpoch ends at 1.
- Training, NumSample=2, NumEpoch=3, iLR=8:
  - Six issues with indices 0,1,0,1,0,1; oMode=1 held.
  - Each pass waits for iBwdDone; oDone after the sixth iBwdDone.
  - With decay: oLR 8→4→2. Without decay: oLR stays 8.
- Backpressure: iReady_Sample low for 5 cycles → oValid_Sample and oSampleIdx stable for all 5 cycles; exactly one handshake.
- NumSample=0 start → oBusy high for 1 cycle (DONE), oDone pulse, oValid_Sample never asserted.
- iAbort in BWD of sample 1 → IDLE next cycle, no oDone. A new iStart restarts at idx 0, epoch 0.
- iRST low during FWD → all outputs at reset values asynchronously. A stray iFwdDone after release has no effect; an iStart during a run is ignored.
